// File: rtl/subsys_power_seq_if.sv
// Control/status bundle between the PMU register side and the power sequencer.
// The master drives per-domain requests; the slave (sequencer) drives power-gating controls.
interface subsys_power_seq_if #(
  parameter int unsigned N_DOMAINS = 4
) ();
  logic [N_DOMAINS-1:0] enable_power;
  logic [N_DOMAINS-1:0] power_switch_en;
  logic [N_DOMAINS-1:0] iso_en;
  logic [N_DOMAINS-1:0] clk_en;
  logic [N_DOMAINS-1:0] reset_gated_out;
  logic [N_DOMAINS-1:0] power_domain_on;
  logic [N_DOMAINS-1:0] busy;

  modport master (
    output enable_power,
    input  power_switch_en,
    input  iso_en,
    input  clk_en,
    input  reset_gated_out,
    input  power_domain_on,
    input  busy
  );

  modport slave (
    input  enable_power,
    output power_switch_en,
    output iso_en,
    output clk_en,
    output reset_gated_out,
    output power_domain_on,
    output busy
  );
endinterface

// File: rtl/subsys_power_seq.sv
// Multi-domain power sequencer: per-domain FSM orders switch, isolation, clock enable and
// reset on power-up and reverses the order on power-down. All outputs are registered.
module subsys_power_seq #(
  parameter int unsigned N_DOMAINS     = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned RST_HOLD      = 4
) (
  input  logic               clk_in,
  input  logic               reset_in,
  subsys_power_seq_if.slave  pwr_if
);

  typedef enum logic [2:0] {
    StOff,
    StPwrUp,
    StIsoRel,
    StClkOn,
    StOn,
    StRstAssert,
    StClkOff,
    StPwrDn
  } state_e;

  // Counters hold "remaining cycles minus one" so a value of 0 means leave on the next edge.
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLoad   = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e               state_q [N_DOMAINS];
  state_e               state_d [N_DOMAINS];
  logic [CNT_W-1:0]     cnt_q   [N_DOMAINS];
  logic [CNT_W-1:0]     cnt_d   [N_DOMAINS];

  logic [N_DOMAINS-1:0] sw_q,   sw_d;
  logic [N_DOMAINS-1:0] iso_q,  iso_d;
  logic [N_DOMAINS-1:0] clk_q,  clk_d;
  logic [N_DOMAINS-1:0] rst_q,  rst_d;
  logic [N_DOMAINS-1:0] on_q,   on_d;
  logic [N_DOMAINS-1:0] busy_q, busy_d;

  always_comb begin
    sw_d   = '0;
    iso_d  = '1;
    clk_d  = '0;
    rst_d  = '1;
    on_d   = '0;
    busy_d = '0;
    for (int i = 0; i < int'(N_DOMAINS); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StOff: begin
          if (pwr_if.enable_power[i]) begin
            state_d[i] = StPwrUp;
            cnt_d[i]   = SettleLoad;
          end
        end
        StPwrUp: begin
          if (cnt_q[i] == '0) state_d[i] = StIsoRel;
          else                cnt_d[i]   = cnt_q[i] - CntOne;
        end
        StIsoRel: begin
          state_d[i] = StClkOn;
          cnt_d[i]   = HoldLoad;
        end
        StClkOn: begin
          if (cnt_q[i] == '0) state_d[i] = StOn;
          else                cnt_d[i]   = cnt_q[i] - CntOne;
        end
        StOn: begin
          if (!pwr_if.enable_power[i]) begin
            state_d[i] = StRstAssert;
            cnt_d[i]   = HoldLoad;
          end
        end
        StRstAssert: begin
          if (cnt_q[i] == '0) state_d[i] = StClkOff;
          else                cnt_d[i]   = cnt_q[i] - CntOne;
        end
        StClkOff: begin
          state_d[i] = StPwrDn;
          cnt_d[i]   = SettleLoad;
        end
        StPwrDn: begin
          if (cnt_q[i] == '0) state_d[i] = StOff;
          else                cnt_d[i]   = cnt_q[i] - CntOne;
        end
        default: state_d[i] = StOff;
      endcase

      // Outputs are decoded from the next state so they register alongside the state.
      sw_d[i]   = (state_d[i] != StOff) && (state_d[i] != StPwrDn);
      iso_d[i]  = (state_d[i] == StOff) || (state_d[i] == StPwrUp) || (state_d[i] == StPwrDn);
      clk_d[i]  = (state_d[i] == StClkOn) || (state_d[i] == StOn) ||
                  (state_d[i] == StRstAssert);
      rst_d[i]  = (state_d[i] != StOn);
      on_d[i]   = (state_d[i] == StOn);
      busy_d[i] = (state_d[i] != StOff) && (state_d[i] != StOn);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < int'(N_DOMAINS); i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
      end
      sw_q   <= '0;
      iso_q  <= '1;
      clk_q  <= '0;
      rst_q  <= '1;
      on_q   <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_DOMAINS); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sw_q   <= sw_d;
      iso_q  <= iso_d;
      clk_q  <= clk_d;
      rst_q  <= rst_d;
      on_q   <= on_d;
      busy_q <= busy_d;
    end
  end

  assign pwr_if.power_switch_en = sw_q;
  assign pwr_if.iso_en          = iso_q;
  assign pwr_if.clk_en          = clk_q;
  assign pwr_if.reset_gated_out = rst_q;
  assign pwr_if.power_domain_on = on_q;
  assign pwr_if.busy            = busy_q;

  // Safe-ordering invariants, bitwise across all domains.
  a_iso_needs_sw: assert property (@(posedge clk_in) disable iff (reset_in)
    ((~iso_q & ~sw_q) == '0));
  a_clk_needs_iso_off: assert property (@(posedge clk_in) disable iff (reset_in)
    ((clk_q & iso_q) == '0));
  a_rst_rel_needs_clk: assert property (@(posedge clk_in) disable iff (reset_in)
    ((~rst_q & ~clk_q) == '0));

endmodule

// File: doc/subsys_power_seq.md
Name: subsys_power_seq

Overview:
- Parametrised multi-domain power sequencer; next generation of the subsystem power-gate stub.
- Each of N_DOMAINS domains has an independent FSM that orders power-switch, isolation, clock-enable and reset on power-up, and reverses the order on power-down.
- Settle and reset-hold times are programmable counts.
- Sits between PMU/subsystem control registers and the per-domain switch cells, isolation cells and library ICGs. The block drives clock *enables* and never a gated clock.

Parameters:
- N_DOMAINS, 4: number of independently sequenced power domains (≥1).
- CNT_W, 8: width of the per-domain delay counter.
- SETTLE_CYCLES, 16: cycles spent in PWR_UP and PWR_DN. Range 1..2^CNT_W.
- RST_HOLD, 4: cycles reset stays asserted with the clock running, on both up and down sequences. Range 1..2^CNT_W.

Ports:
- clk_in, input, 1: single clock; all state on rising edge.
- reset_in, input, 1: asynchronous, active-high reset.
- enable_power, input, N_DOMAINS: per-domain level request, 1 = domain on. Assumed synchronous to clk_in.
- power_switch_en, output, N_DOMAINS: per-domain power switch enable.
- iso_en, output, N_DOMAINS: per-domain isolation, 1 = outputs clamped.
- clk_en, output, N_DOMAINS: enable to the external ICG of each domain.
- reset_gated_out, output, N_DOMAINS: per-domain reset, active high.
- power_domain_on, output, N_DOMAINS: 1 only in state ON.
- busy, output, N_DOMAINS: 1 in any transitional state.

Behaviour:
- All outputs are registered.
- Reset values (all bits): power_switch_en=0, iso_en=1, clk_en=0, reset_gated_out=1, power_domain_on=0, busy=0. FSM = OFF.
- reset_in asserted mid-sequence forces the above immediately, with no ordered shutdown.
- FSM states per domain: OFF, PWR_UP, ISO_REL, CLK_ON, ON, RST_ASSERT, CLK_OFF, PWR_DN.
- Output values per state:
  - OFF: sw=0, iso=1, clk=0, rst=1.
  - PWR_UP: sw=1, iso=1, clk=0, rst=1.
  - ISO_REL: sw=1, iso=0, clk=0, rst=1.
  - CLK_ON: sw=1, iso=0, clk=1, rst=1.
  - ON: sw=1, iso=0, clk=1, rst=0, power_domain_on=1.
  - RST_ASSERT: sw=1, iso=0, clk=1, rst=1.
  - CLK_OFF: sw=1, iso=0, clk=0, rst=1.
  - PWR_DN: sw=0, iso=1, clk=0, rst=1.
- Transitions:
  - OFF → PWR_UP when enable_power[i]=1 sampled. Counter loads SETTLE_CYCLES-1.
  - PWR_UP → ISO_REL when the counter reaches 0; otherwise decrement.
  - ISO_REL → CLK_ON unconditionally, after 1 cycle. Counter loads RST_HOLD-1.
  - CLK_ON → ON when the counter reaches 0.
  - ON → RST_ASSERT when enable_power[i]=0 sampled. Counter loads RST_HOLD-1.
  - RST_ASSERT → CLK_OFF when the counter reaches 0.
  - CLK_OFF → PWR_DN unconditionally, after 1 cycle. Counter loads SETTLE_CYCLES-1.
  - PWR_DN → OFF when the counter reaches 0.
- Power-up timing, with E0 = edge sampling request=1 (defaults in brackets):
  - switch_en rises at E0.
  - iso_en falls at E0+SETTLE_CYCLES [+16].
  - clk_en rises at E0+SETTLE_CYCLES+1 [+17].
  - reset_gated_out falls and power_domain_on rises at E0+SETTLE_CYCLES+1+RST_HOLD [+21].
- Power-down timing, with D0 = edge sampling request=0 (defaults in brackets):
  - reset asserts and power_domain_on falls at D0.
  - clk_en falls at D0+RST_HOLD [+4].
  - iso_en and switch off at D0+RST_HOLD+1 [+5].
  - OFF reached (busy falls) at D0+RST_HOLD+1+SETTLE_CYCLES [+21].
- No abort: a request change during a transitional state is ignored until the FSM reaches ON or OFF. The level is then re-evaluated on the next edge. A request toggle shorter than the sequence therefore results in a full up or down cycle.
- Invariants, checked by assertions:
  - iso_en=0 only when power_switch_en=1.
  - clk_en=1 only when iso_en=0.
  - reset_gated_out=0 only when clk_en=1.
- Domains are fully independent; simultaneous requests on multiple domains sequence in parallel.
- SETTLE_CYCLES=1 or RST_HOLD=1 each give a 1-cycle stay in the corresponding state.

Test Plan:
- Reset: assert reset_in asynchronously mid-cycle → all outputs take their reset values immediately. Release → values hold while enable_power=0.
- Power-up, defaults, domain 0: raise enable_power[0] at E0 → sw@E0, iso low @E0+16, clk_en @E0+17, reset low + power_domain_on @E0+21. busy high from E0 until E0+21.
- Power-down from ON: drop request at D0 → reset @D0, clk_en low @D0+4, iso=1/sw=0 @D0+5, busy low @D0+21. Invariants hold at every edge.
- Request glitch: 1-cycle pulse on enable_power[1] from OFF → full power-up to ON, then full power-down to OFF. Pulse low for 1 cycle while in PWR_UP → no effect, domain ends ON.
- Reset mid-sequence: assert reset_in in CLK_ON of domain 2 → immediate OFF values with no intermediate ordering. After release, domain 2 re-sequences from OFF if the request is still high.
- Parallel/params: N_DOMAINS=4, SETTLE_CYCLES=1, RST_HOLD=1, all requests raised in the same cycle → all domains reach ON at E0+3 simultaneously. Domain 3 dropped while others stay on → only domain 3 outputs change.
